// File: rtl/alu_seq_if.sv
// alu_seq_if: request/response bundle for the sequential ALU.
// Request side carries opcode and operands; response side carries the
// registered result, the multiply high half and the four status flags.
// The opcode encodings live here so that the ALU and its users share one definition.

`ifndef OP_ADD
`define OP_ADD 4'd0
`define OP_SUB 4'd1
`define OP_SHL 4'd2
`define OP_SHR 4'd3
`define OP_AND 4'd4
`define OP_OR  4'd5
`define OP_XOR 4'd6
`define OP_MUL 4'd7
`endif

interface alu_seq_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       operation;
    logic [WIDTH-1:0] operand1;
    logic [WIDTH-1:0] operand2;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic [WIDTH-1:0] result_hi;
    logic             zero_flag;
    logic             negative_flag;
    logic             carry_flag;
    logic             overflow_flag;

    // Issue stage / writeback side
    modport master (
        output in_valid, operation, operand1, operand2, out_ready,
        input  in_ready, out_valid, result, result_hi,
               zero_flag, negative_flag, carry_flag, overflow_flag
    );

    // ALU side
    modport slave (
        input  in_valid, operation, operand1, operand2, out_ready,
        output in_ready, out_valid, result, result_hi,
               zero_flag, negative_flag, carry_flag, overflow_flag
    );
endinterface

// File: rtl/alu_seq.sv
// alu_seq: handshaked WIDTH-bit ALU with registered result and flags.
// Single-cycle ops (ADD/SUB/SHL/SHR/AND/OR/XOR) deliver one cycle after
// acceptance. Define ALU_MUL_EN to add an unsigned shift-add multiplier
// (WIDTH iterations in BUSY); without it OP_MUL decodes as ADD and
// result_hi is tied to zero. Undefined opcodes behave as ADD.

module alu_seq #(
    parameter int WIDTH   = 8,
    parameter int SHAMT_W = $clog2(WIDTH) + 1
) (
    input  logic     clk,
    input  logic     rst_n,
    alu_seq_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             zero_q, zero_d;
    logic             neg_q, neg_d;
    logic             carry_q, carry_d;
    logic             ovf_q, ovf_d;

    logic             accept;
    logic             mul_req;
    logic             is_sub;
    logic [WIDTH-1:0] b_eff;
    logic [WIDTH:0]   sum;
    logic             add_ovf;
    logic [SHAMT_W-1:0] shamt;
    logic             shamt_big;
    logic [WIDTH-1:0] alu_res;
    logic             alu_c;
    logic             alu_v;

`ifdef ALU_MUL_EN
    logic [WIDTH-1:0]   mcand_q, mcand_d;
    logic [WIDTH-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   result_hi_q, result_hi_d;
    logic [2*WIDTH-1:0] prod_q, prod_d;
    logic [WIDTH:0]     part_sum;

    assign mul_req       = (bus.operation == `OP_MUL);
    assign bus.result_hi = result_hi_q;
`else
    assign mul_req       = 1'b0;
    assign bus.result_hi = '0;
`endif

    // Ready depends only on state and the consumer; never on in_valid.
    assign bus.in_ready = (state_q == IDLE) || ((state_q == DONE) && bus.out_ready);
    assign accept       = bus.in_valid && bus.in_ready;

    assign bus.out_valid     = out_valid_q;
    assign bus.result        = result_q;
    assign bus.zero_flag     = zero_q;
    assign bus.negative_flag = neg_q;
    assign bus.carry_flag    = carry_q;
    assign bus.overflow_flag = ovf_q;

    // Single-cycle datapath: one shared adder for ADD/SUB, shifts and logic ops.
    always_comb begin
        is_sub    = (bus.operation == `OP_SUB);
        b_eff     = is_sub ? ~bus.operand2 : bus.operand2;
        sum       = {1'b0, bus.operand1} + {1'b0, b_eff} + {{WIDTH{1'b0}}, is_sub};
        add_ovf   = (bus.operand1[WIDTH-1] == b_eff[WIDTH-1]) &&
                    (sum[WIDTH-1] != bus.operand1[WIDTH-1]);
        shamt     = bus.operand2[SHAMT_W-1:0];
        shamt_big = (int'(shamt) >= WIDTH);
        alu_res   = sum[WIDTH-1:0];
        alu_c     = sum[WIDTH];
        alu_v     = add_ovf;
        case (bus.operation)
            `OP_SHL: begin
                alu_res = shamt_big ? '0 : (bus.operand1 << shamt);
                alu_c   = 1'b0;
                alu_v   = 1'b0;
            end
            `OP_SHR: begin
                alu_res = shamt_big ? '0 : (bus.operand1 >> shamt);
                alu_c   = 1'b0;
                alu_v   = 1'b0;
            end
            `OP_AND: begin
                alu_res = bus.operand1 & bus.operand2;
                alu_c   = 1'b0;
                alu_v   = 1'b0;
            end
            `OP_OR: begin
                alu_res = bus.operand1 | bus.operand2;
                alu_c   = 1'b0;
                alu_v   = 1'b0;
            end
            `OP_XOR: begin
                alu_res = bus.operand1 ^ bus.operand2;
                alu_c   = 1'b0;
                alu_v   = 1'b0;
            end
            default: begin
                // ADD, SUB, undefined opcodes (and MUL when the multiplier is absent)
            end
        endcase
    end

    // Next-state and next-output logic; outputs only change when a result completes.
    always_comb begin
        state_d     = state_q;
        out_valid_d = out_valid_q;
        result_d    = result_q;
        zero_d      = zero_q;
        neg_d       = neg_q;
        carry_d     = carry_q;
        ovf_d       = ovf_q;
`ifdef ALU_MUL_EN
        mcand_d     = mcand_q;
        cnt_d       = cnt_q;
        result_hi_d = result_hi_q;
        prod_d      = prod_q;
        // One shift-add step: add multiplicand into the high half if the
        // current multiplier LSB is set, then shift the whole product right.
        part_sum    = {1'b0, prod_q[2*WIDTH-1:WIDTH]} +
                      (prod_q[0] ? {1'b0, mcand_q} : {(WIDTH+1){1'b0}});
`endif
        case (state_q)
            IDLE, DONE: begin
                if (accept && !mul_req) begin
                    state_d     = DONE;
                    out_valid_d = 1'b1;
                    result_d    = alu_res;
                    zero_d      = ~|alu_res;
                    neg_d       = alu_res[WIDTH-1];
                    carry_d     = alu_c;
                    ovf_d       = alu_v;
`ifdef ALU_MUL_EN
                    result_hi_d = '0;
`endif
                end
`ifdef ALU_MUL_EN
                else if (accept) begin
                    // Previous result stays on the outputs, but is no longer valid.
                    state_d     = BUSY;
                    out_valid_d = 1'b0;
                    mcand_d     = bus.operand1;
                    prod_d      = {{WIDTH{1'b0}}, bus.operand2};
                    cnt_d       = '0;
                end
`endif
                else if ((state_q == DONE) && bus.out_ready) begin
                    state_d     = IDLE;
                    out_valid_d = 1'b0;
                end
            end
`ifdef ALU_MUL_EN
            BUSY: begin
                prod_d = {part_sum, prod_q[WIDTH-1:1]};
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == WIDTH'(WIDTH - 1)) begin
                    state_d     = DONE;
                    out_valid_d = 1'b1;
                    result_d    = prod_d[WIDTH-1:0];
                    result_hi_d = prod_d[2*WIDTH-1:WIDTH];
                    zero_d      = ~|prod_d[WIDTH-1:0];
                    neg_d       = prod_d[WIDTH-1];
                    carry_d     = |prod_d[2*WIDTH-1:WIDTH];
                    ovf_d       = 1'b0;
                end
            end
`endif
            default: begin
                state_d     = IDLE;
                out_valid_d = 1'b0;
            end
        endcase
    end

    // State and output registers; reset aborts any multiply in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            zero_q      <= 1'b0;
            neg_q       <= 1'b0;
            carry_q     <= 1'b0;
            ovf_q       <= 1'b0;
`ifdef ALU_MUL_EN
            mcand_q     <= '0;
            cnt_q       <= '0;
            result_hi_q <= '0;
            prod_q      <= '0;
`endif
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            zero_q      <= zero_d;
            neg_q       <= neg_d;
            carry_q     <= carry_d;
            ovf_q       <= ovf_d;
`ifdef ALU_MUL_EN
            mcand_q     <= mcand_d;
            cnt_q       <= cnt_d;
            result_hi_q <= result_hi_d;
            prod_q      <= prod_d;
`endif
        end
    end

endmodule
